// File: rtl/proc_packet_arbiter.sv
// proc_packet_arbiter
//   Round-robin arbiter sharing the single Garnet proc_packet port between
//   NUM_REQ requesters. Granted write/read packets are registered onto the
//   shared port one cycle after the grant. Read requester IDs are kept in an
//   in-order FIFO so each rd_data_valid return is steered back to its issuer.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   req_wr_en/strb/addr/data    per-requester write request and payload
//   req_rd_en/rd_addr           per-requester read request and address
//   req_gnt                     one-hot grant, combinational
//   req_rd_data(_valid)         read return, routed combinationally
//   proc_packet_wr_*/rd_*       registered shared packet port
//   proc_packet_rd_data(_valid) shared read return
//   err_unexpected_rd           sticky: return arrived with no read outstanding
//   perf_gnt_cnt/perf_stall_cnt only with PROC_ARB_PERF_CNT_EN defined
//
// Optional feature macro: PROC_ARB_PERF_CNT_EN (per-requester grant and stall
// counters, saturating at 32'hFFFF_FFFF).

module proc_packet_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int ADDR_WIDTH      = 20,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_wr_en,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]    req_wr_strb,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wr_data,
  input  logic [NUM_REQ-1:0]                 req_rd_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_rd_addr,
  output logic [NUM_REQ-1:0]                 req_gnt,
  output logic [DATA_WIDTH-1:0]              req_rd_data,
  output logic [NUM_REQ-1:0]                 req_rd_data_valid,
  output logic                               proc_packet_wr_en,
  output logic [DATA_WIDTH/8-1:0]            proc_packet_wr_strb,
  output logic [ADDR_WIDTH-1:0]              proc_packet_wr_addr,
  output logic [DATA_WIDTH-1:0]              proc_packet_wr_data,
  output logic                               proc_packet_rd_en,
  output logic [ADDR_WIDTH-1:0]              proc_packet_rd_addr,
  input  logic [DATA_WIDTH-1:0]              proc_packet_rd_data,
  input  logic                               proc_packet_rd_data_valid,
  output logic                               err_unexpected_rd
`ifdef PROC_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*32-1:0]              perf_gnt_cnt,
  output logic [NUM_REQ*32-1:0]              perf_stall_cnt
`endif
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(MAX_OUTSTANDING);
  localparam int CW  = PW + 1;

  logic [IDW-1:0]        last_gnt_q;
  logic [IDW-1:0]        id_mem_q [MAX_OUTSTANDING];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  err_q;

  logic                  wr_en_q;
  logic [SW-1:0]         wr_strb_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [NUM_REQ-1:0]    eligible;
  logic                  gnt_valid;
  logic [IDW-1:0]        gnt_idx;
  logic                  gnt_is_wr;
  logic                  push;
  logic                  pop;
  logic [IDW-1:0]        head_id;

  // Full is taken from the registered count only, so a return in this cycle
  // never frees a slot for a read granted in the same cycle.
  assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);

  assign eligible = req_wr_en | (req_rd_en & {NUM_REQ{~fifo_full}});

  // Search last_gnt+1 .. last_gnt+NUM_REQ, wrapping without a modulo operator.
  always_comb begin
    int cand;
    cand      = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_gnt_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!gnt_valid && eligible[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    req_gnt = '0;
    if (gnt_valid) req_gnt[gnt_idx] = 1'b1;
  end

  // A requester raising both enables gets its write first.
  assign gnt_is_wr = req_wr_en[gnt_idx];
  assign push      = gnt_valid & ~gnt_is_wr;
  assign pop       = proc_packet_rd_data_valid & ~fifo_empty;
  assign head_id   = id_mem_q[rd_ptr_q];

  always_comb begin
    req_rd_data_valid = '0;
    if (pop) req_rd_data_valid[head_id] = 1'b1;
  end

  assign req_rd_data = pop ? proc_packet_rd_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt_q <= IDW'(NUM_REQ - 1);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_strb_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      if (gnt_valid) last_gnt_q <= gnt_idx;

      wr_en_q <= gnt_valid & gnt_is_wr;
      if (gnt_valid && gnt_is_wr) begin
        wr_strb_q <= req_wr_strb[gnt_idx*SW +: SW];
        wr_addr_q <= req_wr_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        wr_data_q <= req_wr_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      end

      rd_en_q <= push;
      if (push) rd_addr_q <= req_rd_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];

      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      if (proc_packet_rd_data_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read below count_q.
  always_ff @(posedge clk) begin
    if (push) id_mem_q[wr_ptr_q] <= gnt_idx;
  end

  assign proc_packet_wr_en   = wr_en_q;
  assign proc_packet_wr_strb = wr_strb_q;
  assign proc_packet_wr_addr = wr_addr_q;
  assign proc_packet_wr_data = wr_data_q;
  assign proc_packet_rd_en   = rd_en_q;
  assign proc_packet_rd_addr = rd_addr_q;
  assign err_unexpected_rd   = err_q;

`ifdef PROC_ARB_PERF_CNT_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    logic [31:0] gnt_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        req_any;

    assign req_any = req_wr_en[g] | req_rd_en[g];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        gnt_cnt_q   <= '0;
        stall_cnt_q <= '0;
      end else begin
        if (req_gnt[g] && (gnt_cnt_q != '1)) gnt_cnt_q <= gnt_cnt_q + 32'd1;
        if (req_any && !req_gnt[g] && (stall_cnt_q != '1))
          stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end

    assign perf_gnt_cnt[g*32 +: 32]   = gnt_cnt_q;
    assign perf_stall_cnt[g*32 +: 32] = stall_cnt_q;
  end
`endif

endmodule

// File: tb/tb_proc_packet_arbiter.sv
module tb_proc_packet_arbiter;

  localparam int N  = 3;
  localparam int AW = 20;
  localparam int DW = 64;
  localparam int MO = 4;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_wr_en = '0;
  logic [N*SW-1:0]   req_wr_strb = '0;
  logic [N*AW-1:0]   req_wr_addr = '0;
  logic [N*DW-1:0]   req_wr_data = '0;
  logic [N-1:0]      req_rd_en = '0;
  logic [N*AW-1:0]   req_rd_addr = '0;
  logic [N-1:0]      req_gnt;
  logic [DW-1:0]     req_rd_data;
  logic [N-1:0]      req_rd_data_valid;
  logic              proc_packet_wr_en;
  logic [SW-1:0]     proc_packet_wr_strb;
  logic [AW-1:0]     proc_packet_wr_addr;
  logic [DW-1:0]     proc_packet_wr_data;
  logic              proc_packet_rd_en;
  logic [AW-1:0]     proc_packet_rd_addr;
  logic [DW-1:0]     proc_packet_rd_data = '0;
  logic              proc_packet_rd_data_valid = 1'b0;
  logic              err_unexpected_rd;
`ifdef PROC_ARB_PERF_CNT_EN
  logic [N*32-1:0]   perf_gnt_cnt;
  logic [N*32-1:0]   perf_stall_cnt;
`endif

  proc_packet_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_wr_en(req_wr_en),
    .req_wr_strb(req_wr_strb),
    .req_wr_addr(req_wr_addr),
    .req_wr_data(req_wr_data),
    .req_rd_en(req_rd_en),
    .req_rd_addr(req_rd_addr),
    .req_gnt(req_gnt),
    .req_rd_data(req_rd_data),
    .req_rd_data_valid(req_rd_data_valid),
    .proc_packet_wr_en(proc_packet_wr_en),
    .proc_packet_wr_strb(proc_packet_wr_strb),
    .proc_packet_wr_addr(proc_packet_wr_addr),
    .proc_packet_wr_data(proc_packet_wr_data),
    .proc_packet_rd_en(proc_packet_rd_en),
    .proc_packet_rd_addr(proc_packet_rd_addr),
    .proc_packet_rd_data(proc_packet_rd_data),
    .proc_packet_rd_data_valid(proc_packet_rd_data_valid),
    .err_unexpected_rd(err_unexpected_rd)
`ifdef PROC_ARB_PERF_CNT_EN
    ,
    .perf_gnt_cnt(perf_gnt_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: pending requests per requester, last winner, queue of
  // outstanding read owners, sticky error, and grant/stall tallies.
  bit              wr_p [N];
  bit              rd_p [N];
  logic [AW-1:0]   wa [N];
  logic [AW-1:0]   ra [N];
  logic [DW-1:0]   wd [N];
  logic [SW-1:0]   ws [N];
  int              last_m;
  int              outq [$];
  bit              err_m;
  longint unsigned gcnt_m [N];
  longint unsigned scnt_m [N];
  bit              ret_now;
  logic [DW-1:0]   ret_data;

  typedef struct {
    bit            wr;
    logic [SW-1:0] strb;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } pkt_t;

  typedef struct {
    logic [N-1:0]  vld;
    logic [DW-1:0] data;
    bit            err;
  } ret_t;

  pkt_t pkt_q [$];
  ret_t ret_q [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      wr_p[i] = 1'b0; rd_p[i] = 1'b0;
      gcnt_m[i] = 0;  scnt_m[i] = 0;
    end
    last_m = N - 1;
    err_m  = 1'b0;
    outq.delete();
    pkt_q.delete();
    ret_q.delete();
    ret_now = 1'b0;
    req_wr_en = '0;
    req_rd_en = '0;
    proc_packet_rd_data_valid = 1'b0;
  endtask

  task automatic reset_checks();
    chk("rst_wr_en",   proc_packet_wr_en, 0);
    chk("rst_wr_strb", proc_packet_wr_strb, 0);
    chk("rst_wr_addr", proc_packet_wr_addr, 0);
    chk("rst_wr_data", proc_packet_wr_data, 0);
    chk("rst_rd_en",   proc_packet_rd_en, 0);
    chk("rst_rd_addr", proc_packet_rd_addr, 0);
    chk("rst_rd_vld",  req_rd_data_valid, 0);
    chk("rst_rd_data", req_rd_data, 0);
    chk("rst_err",     err_unexpected_rd, 0);
    chk("rst_gnt",     req_gnt, 0);
`ifdef PROC_ARB_PERF_CNT_EN
    chk("rst_perf_gnt",   perf_gnt_cnt, 0);
    chk("rst_perf_stall", perf_stall_cnt, 0);
`endif
  endtask

  // Asserted mid-cycle so the asynchronous clear is observed before any edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    reset_checks();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock cycle: drive the model's pending requests, predict the grant
  // and any routed return, and queue the packet expected on the next cycle.
  task automatic step(output int gi);
    bit           full;
    int           c;
    int           id;
    logic [N-1:0] eg;
    ret_t         r;
    pkt_t         p;
    @(posedge clk);
    #1;
    full = (outq.size() >= MO);
    for (int i = 0; i < N; i++) begin
      req_wr_en[i] = wr_p[i];
      req_rd_en[i] = rd_p[i];
      req_wr_strb[i*SW +: SW] = ws[i];
      req_wr_addr[i*AW +: AW] = wa[i];
      req_wr_data[i*DW +: DW] = wd[i];
      req_rd_addr[i*AW +: AW] = ra[i];
    end
    proc_packet_rd_data_valid = ret_now;
    proc_packet_rd_data       = ret_data;
    if (ret_now) begin
      r.vld  = '0;
      r.data = ret_data;
      r.err  = err_m;
      if (outq.size() > 0) begin
        id = outq.pop_front();
        r.vld[id] = 1'b1;
      end else begin
        err_m = 1'b1;
      end
      ret_q.push_back(r);
      ret_now = 1'b0;
    end
    gi = -1;
    for (int k = 1; k <= N; k++) begin
      c = (last_m + k) % N;
      if (gi < 0 && (wr_p[c] || (rd_p[c] && !full))) gi = c;
    end
    for (int i = 0; i < N; i++)
      if (wr_p[i] || rd_p[i]) begin
        if (i == gi) gcnt_m[i]++;
        else         scnt_m[i]++;
      end
    eg = '0;
    if (gi >= 0) eg[gi] = 1'b1;
    #1;
    chk("req_gnt", req_gnt, eg);
    if (gi >= 0) begin
      last_m = gi;
      p.due  = cyc + 1;
      if (wr_p[gi]) begin
        p.wr = 1'b1; p.strb = ws[gi]; p.addr = wa[gi]; p.data = wd[gi];
        wr_p[gi] = 1'b0;
      end else begin
        p.wr = 1'b0; p.strb = '0; p.addr = ra[gi]; p.data = '0;
        outq.push_back(gi);
        rd_p[gi] = 1'b0;
      end
      pkt_q.push_back(p);
    end
  endtask

  task automatic new_req(input int i);
    int sel;
    if (!wr_p[i] && !rd_p[i] && $urandom_range(0, 99) < 35) begin
      sel = $urandom_range(0, 2);
      wr_p[i] = (sel != 1);
      rd_p[i] = (sel != 0);
      wa[i] = AW'($urandom);
      ra[i] = AW'($urandom);
      wd[i] = {$urandom, $urandom};
      ws[i] = SW'($urandom);
    end
  endtask

  task automatic drain();
    int gi;
    bool_loop: for (int n = 0; n < 4 * MO + 4; n++) begin
      if (outq.size() == 0 && !rd_p[0] && !rd_p[1] && !rd_p[2] &&
          !wr_p[0] && !wr_p[1] && !wr_p[2]) break;
      ret_now  = (outq.size() > 0);
      ret_data = {$urandom, $urandom};
      step(gi);
    end
  endtask

  task automatic perf_check(input bit directed);
    longint unsigned g0 [N];
    longint unsigned s0 [N];
    int gi;
    g0 = gcnt_m;
    s0 = scnt_m;
    step(gi);
`ifdef PROC_ARB_PERF_CNT_EN
    for (int i = 0; i < N; i++) begin
      chk($sformatf("perf_gnt_cnt[%0d]", i),   perf_gnt_cnt[i*32 +: 32],   32'(g0[i]));
      chk($sformatf("perf_stall_cnt[%0d]", i), perf_stall_cnt[i*32 +: 32], 32'(s0[i]));
    end
    if (directed) chk("perf_stall_req2", perf_stall_cnt[2*32 +: 32], 32'd3);
`else
    if (directed) chk("perf_absent_gnt", req_gnt, (gi >= 0) ? (1 << gi) : 0);
`endif
  endtask

  // Packet monitor: whenever the shared port carries a packet, pop and compare.
  initial begin : mon_pkt
    pkt_t p;
    forever begin
      @(posedge clk);
      #1;
      if (proc_packet_wr_en || proc_packet_rd_en) begin
        if (pkt_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL pkt_unexpected: got wr_en=%0b rd_en=%0b, expected no packet (cycle %0d)",
                   proc_packet_wr_en, proc_packet_rd_en, cyc);
        end else begin
          p = pkt_q.pop_front();
          chk("pkt_cycle", cyc, p.due);
          chk("pkt_wr_en", proc_packet_wr_en, p.wr);
          chk("pkt_rd_en", proc_packet_rd_en, !p.wr);
          if (p.wr) begin
            chk("pkt_wr_strb", proc_packet_wr_strb, p.strb);
            chk("pkt_wr_addr", proc_packet_wr_addr, p.addr);
            chk("pkt_wr_data", proc_packet_wr_data, p.data);
          end else begin
            chk("pkt_rd_addr", proc_packet_rd_addr, p.addr);
          end
        end
      end else if (pkt_q.size() > 0 && pkt_q[0].due <= cyc) begin
        n_chk++; n_fail++;
        $display("FAIL pkt_missing: got no packet, expected one due at cycle %0d (cycle %0d)",
                 pkt_q[0].due, cyc);
        void'(pkt_q.pop_front());
      end
    end
  end

  // Return monitor: whenever a return is presented, pop and compare routing.
  initial begin : mon_ret
    ret_t r;
    forever begin
      @(negedge clk);
      if (proc_packet_rd_data_valid) begin
        if (ret_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL ret_unexpected: got a return with no prediction (cycle %0d)", cyc);
        end else begin
          r = ret_q.pop_front();
          chk("rd_data_valid", req_rd_data_valid, r.vld);
          if (r.vld != '0) chk("rd_data", req_rd_data, r.data);
          chk("err_flag", err_unexpected_rd, r.err);
        end
      end else begin
        chk("rd_data_valid_idle", req_rd_data_valid, 0);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL timeout: got no finish, expected finish before 1000000 time units");
    $fatal(1, "timeout");
  end

  initial begin : main
    int gi;
    model_clear();
    for (int i = 0; i < N; i++) begin
      wa[i] = '0; ra[i] = '0; wd[i] = '0; ws[i] = '0;
    end
    ret_data = '0;
    #3;
    reset_checks();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single write from requester 1.
    wr_p[1] = 1'b1; wa[1] = 20'h00100; wd[1] = 64'hDEAD_BEEF_0000_0001; ws[1] = 8'hFF;
    step(gi);
    chk("t1_gnt", req_gnt, 3'b010);
    step(gi);

    // All three writing continuously: strict 0,1,2 rotation.
    do_reset();
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < N; i++)
        if (!wr_p[i]) begin
          wr_p[i] = 1'b1; wa[i] = AW'($urandom); wd[i] = {$urandom, $urandom}; ws[i] = SW'($urandom);
        end
      step(gi);
      chk("t2_rr_order", req_gnt, 3'b001 << (j % 3));
    end
    step(gi);
    step(gi);

    // Reads from 2 then 0; returns routed in order.
    rd_p[2] = 1'b1; ra[2] = AW'($urandom);
    step(gi);
    rd_p[0] = 1'b1; ra[0] = AW'($urandom);
    step(gi);
    ret_now = 1'b1; ret_data = 64'hA;
    step(gi);
    #2;
    chk("t3_vld_a",  req_rd_data_valid, 3'b100);
    chk("t3_data_a", req_rd_data, 64'hA);
    ret_now = 1'b1; ret_data = 64'hB;
    step(gi);
    #2;
    chk("t3_vld_b",  req_rd_data_valid, 3'b001);
    chk("t3_data_b", req_rd_data, 64'hB);

    // Fill the ID FIFO from requester 1, then contend with a write.
    for (int j = 0; j < MO; j++) begin
      rd_p[1] = 1'b1; ra[1] = AW'($urandom);
      step(gi);
    end
    rd_p[1] = 1'b1; ra[1] = AW'($urandom);
    wr_p[0] = 1'b1; wa[0] = AW'($urandom); wd[0] = {$urandom, $urandom}; ws[0] = SW'($urandom);
    step(gi);
    chk("t4_write_wins", req_gnt, 3'b001);
    ret_now = 1'b1; ret_data = {$urandom, $urandom};
    step(gi);
    chk("t4_pop_no_free", req_gnt, 3'b000);
    step(gi);
    chk("t4_fifth_read", req_gnt, 3'b010);
    drain();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) new_req(i);
      ret_now  = (outq.size() > 0) && ($urandom_range(0, 2) == 0);
      ret_data = {$urandom, $urandom};
      step(gi);
    end
    drain();
    perf_check(1'b0);

    // Return with nothing outstanding.
    ret_now = 1'b1; ret_data = {$urandom, $urandom};
    step(gi);
    #2;
    chk("t5_no_valid", req_rd_data_valid, 0);
    for (int j = 0; j < 3; j++) begin
      step(gi);
      #2;
      chk("t5_err_sticky", err_unexpected_rd, 1);
    end

    // Reset with two reads outstanding drops their IDs.
    rd_p[0] = 1'b1; ra[0] = AW'($urandom);
    step(gi);
    rd_p[1] = 1'b1; ra[1] = AW'($urandom);
    step(gi);
    step(gi);
    do_reset();
    ret_now = 1'b1; ret_data = {$urandom, $urandom};
    step(gi);
    step(gi);
    #2;
    chk("t6_err_after_reset", err_unexpected_rd, 1);

    // Requester 2 stalls three cycles behind a full ID FIFO.
    do_reset();
    for (int j = 0; j < MO; j++) begin
      rd_p[0] = 1'b1; ra[0] = AW'($urandom);
      step(gi);
    end
    rd_p[2] = 1'b1; ra[2] = AW'($urandom);
    repeat (3) step(gi);
    perf_check(1'b1);
    drain();
    step(gi);
    step(gi);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_packet_arbiter.md
# proc_packet_arbiter

Round-robin arbiter that shares the single processor-packet port of the Garnet global buffer (`proc_packet_*`) between `NUM_REQ` requesters, such as the host bridge, the bitstream/config loader and the test DMA. Write and read packets are registered onto the shared port. An in-order ID FIFO routes each `rd_data_valid` response back to the requester that issued the read. The block sits between the SoC-side masters and the `proc_packet_*` pins of `Garnet`.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters, 2..8.
- `ADDR_WIDTH`, default 20: proc packet address width.
- `DATA_WIDTH`, default 64: proc packet data width. Strobe width is `DATA_WIDTH/8`.
- `MAX_OUTSTANDING`, default 4: depth of the read-ID FIFO, a power of 2 and at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_wr_en`  in  NUM_REQ  per-requester write request.
- `req_wr_strb`  in  NUM_REQ*DATA_WIDTH/8  per-requester byte strobes.
- `req_wr_addr`, `req_rd_addr`  in  NUM_REQ*ADDR_WIDTH  per-requester addresses.
- `req_wr_data`  in  NUM_REQ*DATA_WIDTH  per-requester write data.
- `req_rd_en`  in  NUM_REQ  per-requester read request.
- `req_gnt`  out  NUM_REQ  one-hot grant; the requester's packet is accepted this cycle.
- `req_rd_data`  out  DATA_WIDTH  read data, broadcast to all requesters.
- `req_rd_data_valid`  out  NUM_REQ  one-hot read-return strobe.
- `proc_packet_wr_en`, `proc_packet_wr_strb`, `proc_packet_wr_addr`, `proc_packet_wr_data`  out  1 / DATA_WIDTH/8 / ADDR_WIDTH / DATA_WIDTH  shared write port.
- `proc_packet_rd_en`, `proc_packet_rd_addr`  out  1 / ADDR_WIDTH  shared read port.
- `proc_packet_rd_data`, `proc_packet_rd_data_valid`  in  DATA_WIDTH / 1  shared read return.
- `err_unexpected_rd`  out  1  sticky flag: a read return arrived while no read was outstanding.

## Operation
- A requester is eligible when its `req_wr_en` or `req_rd_en` is high. A read-only request is eligible only when the ID FIFO is not full.
- A requester holds its request and its payload stable until it sees `req_gnt`.
- If a requester asserts both `req_wr_en` and `req_rd_en`, the write is granted first and the read stays pending.
- Round-robin arbitration:
  - Search starts at `last_gnt+1` and wraps modulo `NUM_REQ`.
  - `last_gnt` resets to `NUM_REQ-1`, so requester 0 has first priority.
  - At most one grant per cycle; `last_gnt` updates only on a grant.
- On a write grant, register `proc_packet_wr_en=1` with that requester's strb/addr/data. Otherwise `proc_packet_wr_en=0`.
- On a read grant, register `proc_packet_rd_en=1` with that requester's address, and push the requester index into the ID FIFO.
- Read returns are in order:
  - When `proc_packet_rd_data_valid=1`, pop the FIFO head and assert `req_rd_data_valid[head]`.
  - `req_rd_data` carries `proc_packet_rd_data` in the same cycle.
  - A push and a pop in the same cycle are both performed, and the count is unchanged.
- A return that arrives while the FIFO is empty sets `err_unexpected_rd`. No `req_rd_data_valid` bit is asserted, and the flag clears only on reset.

## Timing
- `req_gnt` is combinational from the requests, the FIFO-full state and `last_gnt`. There is no combinational path from any `proc_packet_*` input to `req_gnt`.
- The shared packet is driven 1 cycle after the grant, from a registered output stage.
- Read return routing is combinational: 0 cycles from `proc_packet_rd_data_valid` to `req_rd_data_valid`.
- The FIFO-full check uses the registered count. A pop in the current cycle does not free a slot until the next cycle.
- Reset values (asynchronous):
  - All `proc_packet_*` outputs are 0, and `req_rd_data_valid` is 0.
  - FIFO is empty, `last_gnt=NUM_REQ-1`, `err_unexpected_rd=0`.
- Assertion of `reset` mid-transaction drops any outstanding read IDs. Returns that arrive after reset are flagged as unexpected.

## Configuration
- `PROC_ARB_PERF_CNT_EN` defined: adds output `perf_gnt_cnt` (NUM_REQ*32).
  - One grant counter per requester, incremented on each grant and saturating at `32'hFFFF_FFFF`.
  - Also adds output `perf_stall_cnt` (NUM_REQ*32), one counter per requester, incremented on each cycle the requester is requesting but not granted.
  - All counters reset to 0.
- Undefined: neither port exists and no counter logic is built.

## Test plan
- Single requester 1 writes addr `0x00100` with data `0xDEAD_BEEF_0000_0001` and strb `0xFF`. Required: `req_gnt=3'b010` in the same cycle, then the write packet on `proc_packet_*` exactly 1 cycle later.
- Writes held continuously on all 3 requesters for 6 cycles. Required: grant order 0,1,2,0,1,2 with exactly one grant per cycle.
- Requester 2 reads, then requester 0 reads. Required: the downstream returns `0xA` and then `0xB`, and `req_rd_data_valid` pulses `3'b100` then `3'b001` with the matching data.
- Requester 1 issues 4 back-to-back reads with no returns. Required: the 5th read is not granted while a write from requester 0 is still granted. After one return, the 5th read is granted on the next cycle.
- `proc_packet_rd_data_valid` pulsed with no read outstanding. Required: `err_unexpected_rd=1`, all `req_rd_data_valid` bits 0, and the flag stays set until `reset`.
- Reset asserted with 2 reads outstanding. Required: all outputs go to 0 immediately and the FIFO is empty. With `PROC_ARB_PERF_CNT_EN` defined, 3 stalled cycles for requester 2 give `perf_stall_cnt[2]=3`.
